// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package seg_scan_ctrl_pkg;

    // Segment lines are active-low, so all-ones is a dark digit.
    localparam logic [6:0] SEG_OFF   = 7'b111_1111;
    // Anodes are active-low; this is the per-bit "digit off" level.
    localparam logic       ANODE_OFF = 1'b1;

    // Bit position of each segment within the segment vector.
    localparam int unsigned SEG_TOP         = 0;
    localparam int unsigned SEG_UPPER_RIGHT = 1;
    localparam int unsigned SEG_LOWER_RIGHT = 2;
    localparam int unsigned SEG_BOTTOM      = 3;
    localparam int unsigned SEG_LOWER_LEFT  = 4;
    localparam int unsigned SEG_UPPER_LEFT  = 5;
    localparam int unsigned SEG_MIDDLE      = 6;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ready handshake bundle carrying the value to display.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    ready;
    logic                    blank_lz;

    modport master (output load, output value, output blank_lz, input ready);
    modport slave  (input load, input value, input blank_lz, output ready);
endinterface

// File: rtl/seg_scan_ctrl_sevenseg.sv
// Hex nibble to active-low seven-segment pattern (bit i = segment i).
module seg_scan_ctrl_sevenseg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup: bit order is middle..top from MSB to LSB.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'b100_0000;
            4'h1: seg = 7'b111_1001;
            4'h2: seg = 7'b010_0100;
            4'h3: seg = 7'b011_0000;
            4'h4: seg = 7'b001_1001;
            4'h5: seg = 7'b001_0010;
            4'h6: seg = 7'b000_0010;
            4'h7: seg = 7'b111_1000;
            4'h8: seg = 7'b000_0000;
            4'h9: seg = 7'b001_0000;
            4'hA: seg = 7'b000_1000;
            4'hB: seg = 7'b000_0011;
            4'hC: seg = 7'b100_0110;
            4'hD: seg = 7'b010_0001;
            4'hE: seg = 7'b000_0110;
            4'hF: seg = 7'b000_1110;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller driving NUM_DIGITS common-anode digits
// through one shared decoder, with frame-atomic value updates.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        bus,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [0:6]            HEX,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(max_u(SHOW_CYCLES, BLANK_CYCLES) + 1);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    scan_state_t         state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                blank_end, show_end;

    logic [VAL_W-1:0]    display, display_next;
    logic [VAL_W-1:0]    shadow;
    logic                pending;
    logic                ready_q;
    logic                commit, accept;

    logic [3:0]          nib_sel;
    logic [6:0]          seg_dec;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                zero_above;
    logic                digit_lit;
    logic [NUM_DIGITS-1:0] en_next;
    logic [6:0]          hex_next, hex_q;
    logic                fd_next;

    // Scan state, slot counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            digit_en   <= {NUM_DIGITS{ANODE_OFF}};
            hex_q      <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            digit_en   <= en_next;
            hex_q      <= hex_next;
            frame_done <= fd_next;
        end
    end

    // Next scan position plus handshake/commit decisions.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt + 1'b1;
        blank_end  = (state == BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
        show_end   = (state == SHOW)  && (cnt == CNT_W'(SHOW_CYCLES - 1));
        if (blank_end) begin
            state_next = SHOW;
            cnt_next   = '0;
        end
        if (show_end) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
        commit       = blank_end && (idx == '0) && pending;
        accept       = bus.load && ready_q;
        display_next = commit ? shadow : display;
    end

    // Output values for the coming cycle; using the post-commit display and
    // next index lets the first lit digit of a frame already show the new value.
    always_comb begin
        nib_sel = 4'h0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) nib_sel = display_next[4*i +: 4];
        end

        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            zero_above = zero_above && (display_next[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lz_blank[NUM_DIGITS-1-k] = zero_above;
        end

        digit_lit = (state_next == SHOW) && !(bus.blank_lz && lz_blank[idx_next]);

        en_next = {NUM_DIGITS{ANODE_OFF}};
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_lit && (idx_next == IDX_W'(i))) en_next[i] = ~ANODE_OFF;
        end

        hex_next = digit_lit ? seg_dec : SEG_OFF;
        fd_next  = show_end && (idx == IDX_W'(NUM_DIGITS - 1));
    end

    // Update handshake: capture into shadow, release it only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            display <= display_next;
            if (commit) begin
                pending <= 1'b0;
                ready_q <= 1'b1;
            end else if (accept) begin
                shadow  <= bus.value;
                pending <= 1'b1;
                ready_q <= 1'b0;
            end
        end
    end

    // HEX is declared [0:6]; map by segment index, not by position.
    always_comb begin
        HEX = SEG_OFF;
        HEX[SEG_TOP]         = hex_q[SEG_TOP];
        HEX[SEG_UPPER_RIGHT] = hex_q[SEG_UPPER_RIGHT];
        HEX[SEG_LOWER_RIGHT] = hex_q[SEG_LOWER_RIGHT];
        HEX[SEG_BOTTOM]      = hex_q[SEG_BOTTOM];
        HEX[SEG_LOWER_LEFT]  = hex_q[SEG_LOWER_LEFT];
        HEX[SEG_UPPER_LEFT]  = hex_q[SEG_UPPER_LEFT];
        HEX[SEG_MIDDLE]      = hex_q[SEG_MIDDLE];
    end

    assign bus.ready = ready_q;

    seg_scan_ctrl_sevenseg u_dec (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a time-based display model.
module tb_seg_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned SHOWC = 4;
    localparam int unsigned BLNK  = 1;
    localparam int unsigned SLOT  = SHOWC + BLNK;
    localparam int unsigned FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] digit_en;
    logic [0:6]    hex_bus;
    logic          frame_done;
    logic [6:0]    hex7;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SHOW_CYCLES  (SHOWC),
        .BLANK_CYCLES (BLNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .digit_en   (digit_en),
        .HEX        (hex_bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Bit i of hex7 is segment i regardless of the port's range direction.
    always_comb begin
        hex7 = '1;
        for (int unsigned i = 0; i < 7; i++) hex7[i] = hex_bus[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard lit-segment masks (active-high, gfedcba), inverted for the display.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] on;
        case (n)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    // Model: position in the frame is pure cycle arithmetic since reset.
    int unsigned   m_k;
    logic          m_valid = 1'b0;
    logic [15:0]   m_disp, m_shadow;
    logic          m_pending;
    logic          m_blz;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; m_disp = '0; m_shadow = '0; m_pending = 1'b0;
            m_blz = bus.blank_lz; m_valid = 1'b1;
        end else if (m_valid) begin
            if ((m_k % FRAME) == BLNK - 1 && m_pending) begin
                m_disp = m_shadow; m_pending = 1'b0;
            end else if (bus.load && !m_pending) begin
                m_shadow = bus.value; m_pending = 1'b1;
            end
            m_blz = bus.blank_lz;
            m_k++;
        end
    end

    int unsigned q, slot, off;
    logic        lit;
    logic [3:0]  e_en, prev_en = 4'hF;
    logic [6:0]  e_hex;

    always @(negedge clk) begin
        if (m_valid) begin
            q    = m_k % FRAME;
            slot = q / SLOT;
            off  = q % SLOT;
            lit  = (off >= BLNK) && !(m_blz && slot > 0 && (m_disp >> (4*slot)) == 16'h0);
            e_en  = lit ? ~(4'b0001 << slot) : 4'hF;
            e_hex = lit ? seg_of(m_disp[4*slot +: 4]) : 7'h7F;
            chk("digit_en", digit_en, e_en);
            chk("hex", hex7, e_hex);
            chk("ready", bus.ready, !m_pending);
            chk("frame_done", frame_done, (m_k > 0 && q == 0));
            chk("inv_onehot", ($countones(~digit_en) <= 1), 1);
            chk("inv_gap", !(prev_en != 4'hF && digit_en != 4'hF && digit_en != prev_en), 1);
            prev_en = digit_en;
        end
    end

    task automatic wait_en(input logic [3:0] target, input string name);
        int n = 0;
        while (digit_en !== target && n < 60) begin @(negedge clk); n++; end
        if (digit_en !== target) chk(name, digit_en, target);
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        if (frame_done !== 1'b1) chk(name, frame_done, 1);
    endtask

    task automatic count_lit(output int lit_cnt, output logic [6:0] d1_hex);
        lit_cnt = 0; d1_hex = 7'h7F;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (digit_en != 4'hF) lit_cnt++;
            if (digit_en == 4'b1101) d1_hex = hex7;
        end
    endtask

    logic [3:0] seq_exp [10] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
    int         n_cyc, n_lit;
    logic [6:0] cap_hex;

    initial begin
        rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_hex", hex7, 7'h7F);

        // Scan order and timing straight after reset.
        for (int i = 0; i < 10; i++) begin
            chk("scan_seq", digit_en, seq_exp[i]);
            if (seq_exp[i] != 4'hF) chk("scan_hex0", hex7, 7'b100_0000);
            @(negedge clk);
        end

        wait_fd("fd_first");
        n_cyc = 0;
        do begin @(negedge clk); n_cyc++; end while (frame_done !== 1'b1 && n_cyc < 60);
        chk("fd_period", n_cyc, 20);

        // Mid-frame load, then an ignored load while busy.
        wait_en(4'b1011, "wait_d2");
        bus.load = 1'b1; bus.value = 16'h1A2F;
        @(negedge clk);
        chk("ready_drop", bus.ready, 0);
        bus.value = 16'hBEEF;
        @(negedge clk);
        bus.load = 1'b0;
        chk("old_frame_d3", hex7, 7'b100_0000);
        wait_fd("fd_commit");
        chk("ready_before_commit", bus.ready, 0);
        @(negedge clk);
        chk("ready_commit", bus.ready, 1);
        chk("new_d0_en", digit_en, 4'b1110);
        chk("new_d0_F", hex7, 7'b000_1110);
        wait_en(4'b1101, "wait_n1"); chk("new_d1_2", hex7, 7'b010_0100);
        wait_en(4'b1011, "wait_n2"); chk("new_d2_A", hex7, 7'b000_1000);
        wait_en(4'b0111, "wait_n3"); chk("new_d3_1", hex7, 7'b111_1001);

        wait_fd("fd_bp");
        @(negedge clk);
        wait_en(4'b0111, "wait_bp3"); chk("bp_ignored_d3", hex7, 7'b111_1001);

        // Retry once ready is back.
        bus.load = 1'b1; bus.value = 16'hBEEF;
        @(negedge clk);
        bus.load = 1'b0;
        chk("retry_ready_drop", bus.ready, 0);
        wait_fd("fd_beef");
        @(negedge clk);
        wait_en(4'b1101, "wait_b1"); chk("beef_d1_E", hex7, 7'b000_0110);
        wait_en(4'b0111, "wait_b3"); chk("beef_d3_B", hex7, 7'b000_0011);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        bus.load = 1'b1; bus.value = 16'h0030;
        @(negedge clk);
        bus.load = 1'b0;
        wait_fd("fd_lz");
        count_lit(n_lit, cap_hex);
        chk("lz_lit_cycles", n_lit, 8);
        chk("lz_d1_3", cap_hex, 7'b011_0000);

        bus.load = 1'b1; bus.value = 16'h0000;
        @(negedge clk);
        bus.load = 1'b0;
        wait_fd("fd_zero");
        count_lit(n_lit, cap_hex);
        chk("zero_lit_cycles", n_lit, 4);

        // Reset during digit 2 with an update pending.
        bus.blank_lz = 1'b0;
        bus.load = 1'b1; bus.value = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        chk("pend_ready", bus.ready, 0);
        wait_en(4'b1011, "wait_rst_d2");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_en", digit_en, 4'hF);
        chk("mid_rst_hex", hex7, 7'h7F);
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_fd", frame_done, 0);
        wait_en(4'b0111, "wait_r3"); chk("discard_d3", hex7, 7'b100_0000);
        wait_fd("fd_after_rst");
        wait_en(4'b0111, "wait_r3b"); chk("discard_d3_next", hex7, 7'b100_0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
